fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that hands the FIFO write port to one requester at a time
// for bursts of up to MAX_BURST words, stalling while the FIFO is full.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]  burst_cnt, burst_cnt_nxt;
    logic [CW-1:0]  cnt_inc;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] idx;
    logic           pick_found;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr + IDW'(i);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    assign cnt_inc = burst_cnt + CW'(1);

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        grant_valid   = (state == BURST);
        write_enable  = (state == BURST) && req[owner] && !fifo_full;
        write_data    = grant_valid ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
        ack           = '0;
        if (write_enable) ack[owner] = 1'b1;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = BURST;
                    owner_nxt     = pick_id;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                // A dropped request ends the burst even while the FIFO is full.
                if (!req[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner + IDW'(1);
                end else if (write_enable) begin
                    burst_cnt_nxt = cnt_inc;
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = owner + IDW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_id = owner;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle expected grant/write traces,
// reset behaviour, fairness, stall, early drop and a data-integrity run.
module tb_fifo_write_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        fifo_full = 1'b0;
    logic        write_enable;
    logic [7:0]  write_data;
    logic        grant_valid;
    logic [1:0]  grant_id;

    // Second instance with single-word bursts.
    logic [3:0]  req_b = '0;
    logic [31:0] req_data_b = '0;
    logic [3:0]  ack_b;
    logic        fifo_full_b = 1'b0;
    logic        write_enable_b;
    logic [7:0]  write_data_b;
    logic        grant_valid_b;
    logic [1:0]  grant_id_b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          words_left[4];
    int          sent_idx[4];
    int          n_writes;
    logic [3:0]  last_ack;
    logic [7:0]  exp_q[$];
    logic        full_q[$];

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .write_enable(write_enable), .write_data(write_data),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(req_data_b), .ack(ack_b),
        .fifo_full(fifo_full_b), .write_enable(write_enable_b), .write_data(write_data_b),
        .grant_valid(grant_valid_b), .grant_id(grant_id_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] word_of(input int k);
        logic [3:0] kk;
        logic [3:0] nn;
        kk = 4'(k);
        nn = 4'(sent_idx[k]);
        return {kk, nn};
    endfunction

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req[k] = (words_left[k] > 0);
            req_data[k*8 +: 8] = word_of(k);
        end
        fifo_full = (full_q.size() > 0) ? full_q.pop_front() : 1'b0;
    endtask

    // Trace code per cycle: {grant_valid, write_enable, 4'b0, grant_id}.
    task automatic sample_cycle(input bit use_trace);
        logic [7:0] code;
        logic [3:0] exp_ack;
        logic [7:0] exp_data;
        drive();
        #1;
        if (use_trace) begin
            if (exp_q.size() == 0) begin
                check("trace_underrun", 32'd1, 32'd0);
            end else begin
                code = exp_q.pop_front();
                check("grant_valid", 32'(grant_valid), 32'(code[7]));
                check("write_enable", 32'(write_enable), 32'(code[6]));
                if (code[7]) check("grant_id", 32'(grant_id), 32'(code[1:0]));
                exp_ack = code[6] ? 4'(4'b0001 << code[1:0]) : 4'b0000;
                check("ack", 32'(ack), 32'(exp_ack));
                exp_data = code[7] ? word_of(int'(code[1:0])) : 8'h00;
                check("write_data", 32'(write_data), 32'(exp_data));
            end
        end
        last_ack = ack;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (last_ack[k]) begin
                words_left[k]--;
                sent_idx[k]++;
                n_writes++;
            end
        end
    endtask

    task automatic run_trace(input int n);
        repeat (n) begin
            sample_cycle(1'b1);
            advance();
        end
        check("trace_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_trace(input logic [7:0] code, input int n);
        repeat (n) exp_q.push_back(code);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            words_left[k] = 0;
            sent_idx[k] = 0;
        end
        exp_q.delete();
        full_q.delete();
        n_writes = 0;
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // Outputs stay zero in reset even with every requester asking.
        reset_n = 1'b0;
        req = 4'b1111;
        req_data = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);

        // Single requester, 6 words: 4-word burst, idle, 2 words, drop, idle.
        do_reset();
        words_left[2] = 6;
        push_trace(8'h00, 1); push_trace(8'hC2, 4); push_trace(8'h00, 1);
        push_trace(8'hC2, 2); push_trace(8'h82, 1); push_trace(8'h00, 1);
        run_trace(10);
        check("single_writes", 32'(n_writes), 32'd6);

        // All requesting: order 0,1,2,3,0 with 4 words each.
        do_reset();
        for (int k = 0; k < 4; k++) words_left[k] = 8;
        push_trace(8'h00, 1); push_trace(8'hC0, 4);
        push_trace(8'h00, 1); push_trace(8'hC1, 4);
        push_trace(8'h00, 1); push_trace(8'hC2, 4);
        push_trace(8'h00, 1); push_trace(8'hC3, 4);
        push_trace(8'h00, 1); push_trace(8'hC0, 4);
        run_trace(25);

        // FIFO full for 3 cycles after the second write of a burst.
        do_reset();
        words_left[0] = 5;
        for (int i = 0; i < 3; i++) full_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) full_q.push_back(1'b1);
        push_trace(8'h00, 1); push_trace(8'hC0, 2); push_trace(8'h80, 3);
        push_trace(8'hC0, 2); push_trace(8'h00, 1); push_trace(8'hC0, 1);
        push_trace(8'h80, 1); push_trace(8'h00, 1);
        run_trace(12);

        // Owner 1 drops after 2 words while 3 keeps requesting.
        do_reset();
        words_left[1] = 2;
        words_left[3] = 4;
        push_trace(8'h00, 1); push_trace(8'hC1, 2); push_trace(8'h81, 1);
        push_trace(8'h00, 1); push_trace(8'hC3, 4); push_trace(8'h00, 1);
        run_trace(10);

        // Reset during the third write of a burst.
        do_reset();
        words_left[0] = 8;
        push_trace(8'h00, 1); push_trace(8'hC0, 2);
        run_trace(3);
        sample_cycle(1'b0);
        check("pre_reset_write_enable", 32'(write_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_grant_valid", 32'(grant_valid), 32'd0);
        check("midrst_write_enable", 32'(write_enable), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_write_data", 32'(write_data), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        words_left[0] = 0;
        words_left[1] = 2;
        words_left[3] = 2;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_trace(8'h00, 1); push_trace(8'hC1, 2); push_trace(8'h81, 1);
        push_trace(8'h00, 1); push_trace(8'hC3, 2); push_trace(8'h83, 1);
        push_trace(8'h00, 1);
        run_trace(9);

        // Data integrity: 16 tagged words per requester with periodic stalls.
        do_reset();
        for (int k = 0; k < 4; k++) words_left[k] = 16;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (words_left[0] + words_left[1] + words_left[2] + words_left[3] == 0) break;
            full_q.push_back((cyc % 7) == 3);
            sample_cycle(1'b0);
            if (ack != 4'b0000) begin
                int id;
                id = 0;
                for (int k = 0; k < 4; k++) if (ack[k]) id = k;
                check("int_ack_onehot", 32'($onehot(ack)), 32'd1);
                check("int_write_enable", 32'(write_enable), 32'd1);
                check("int_grant_id", 32'(grant_id), 32'(id));
                check("int_write_data", 32'(write_data), 32'(word_of(id)));
            end
            if (fifo_full) check("int_stall_no_write", 32'(write_enable), 32'd0);
            advance();
        end
        check("int_total_writes", 32'(n_writes), 32'd64);
        for (int k = 0; k < 4; k++) check("int_words_left", 32'(words_left[k]), 32'd0);

        // Single-word bursts: write, idle, write, idle...
        do_reset();
        req_b = 4'b0010;
        req_data_b = 32'h0000_5A00;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("mb1_grant_valid", 32'(grant_valid_b), 32'(i % 2));
            check("mb1_write_enable", 32'(write_enable_b), 32'(i % 2));
            if (i % 2 == 1) check("mb1_write_data", 32'(write_data_b), 32'h5A);
            @(posedge clk);
            #1;
        end
        req_b = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
